// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns the raw board reset (rst, async active-low) into clk-aligned,
//   sequenced active-low stage resets. Assertion is asynchronous, release
//   is synchronised through a SYNC_STAGES-deep chain and then staged:
//   bit 0 after HOLD_CYCLES, each further bit STAGE_GAP cycles later,
//   with rst_done flagging that every stage is out of reset.
//   Optional feature macro: RESET_SEQ_SW_RST_EN (software restart from DONE).
//   Every output is driven directly by an async-cleared flop.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic                  rst_done,
   output logic [1:0]            seq_state
);

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_REL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [NUM_STAGES-1:0] FIRST_BIT = NUM_STAGES'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rst_sync;

   logic [1:0]             state_q;
   logic [1:0]             state_nxt;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [NUM_STAGES-1:0]  out_nxt;
   logic                   done_nxt;

   // Stages release strictly in order, so the output vector is a thermometer
   // code; the next release pattern is the current one shifted up with a 1.
   logic [NUM_STAGES-1:0]  out_shift;
   logic                   cnt_last;
   logic                   step;

`ifndef RESET_SEQ_SW_RST_EN
   // Port kept for a uniform interface; nothing consumes it in this build.
   logic                   unused_sw_rst_req;
   assign unused_sw_rst_req = sw_rst_req;
`endif

   assign rst_sync  = sync_q[SYNC_STAGES-1];
   assign out_shift = (rst_out_n << 1) | FIRST_BIT;
   assign cnt_last  = (state_q == ST_HOLD) ? (cnt_q == HOLD_LAST)
                                           : (cnt_q == GAP_LAST);
   // A release happens only once the synchronised reset is high and the
   // current wait period has run out.
   assign step      = rst_sync && cnt_last;
   assign seq_state = state_q;

   // De-assert synchroniser: shifts in 1s after rst rises, clears at once on rst low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // State, counter and output registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_HOLD;
         cnt_q     <= '0;
         rst_out_n <= '0;
         rst_done  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         rst_out_n <= out_nxt;
         rst_done  <= done_nxt;
      end
   end

   // Next-state: HOLD -> REL/DONE on the first release, REL -> DONE on the last.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_HOLD, ST_REL: begin
            if (step) begin
               state_nxt = (&out_shift) ? ST_DONE : ST_REL;
            end
         end
         ST_DONE: begin
`ifdef RESET_SEQ_SW_RST_EN
            if (sw_rst_req) begin
               state_nxt = ST_HOLD;
            end
`endif
         end
         default: state_nxt = ST_HOLD;
      endcase
   end

   // Next values for counter and outputs; the illegal state clears everything.
   always_comb begin
      cnt_nxt  = cnt_q;
      out_nxt  = rst_out_n;
      done_nxt = rst_done;
      case (state_q)
         ST_HOLD, ST_REL: begin
            if (step) begin
               out_nxt  = out_shift;
               done_nxt = &out_shift;
               cnt_nxt  = '0;
            end else if (rst_sync) begin
               cnt_nxt  = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
`ifdef RESET_SEQ_SW_RST_EN
            if (sw_rst_req) begin
               out_nxt  = '0;
               done_nxt = 1'b0;
               cnt_nxt  = '0;
            end
`endif
         end
         default: begin
            out_nxt  = '0;
            done_nxt = 1'b0;
            cnt_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Drives two instances (default parameters, and the minimal
//   NUM_STAGES=1/HOLD=1/GAP=1 configuration) from one clock and reset.
//   Expected outputs come from release-edge arithmetic: edges are counted
//   from the last reset release (or from a software restart edge).
module tb_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       sw_rst_req;
   logic [2:0] a_out;
   logic       a_done;
   logic [1:0] a_state;
   logic [0:0] b_out;
   logic       b_done;
   logic [1:0] b_state;

   int total = 0;
   int bad   = 0;

`ifdef RESET_SEQ_SW_RST_EN
   localparam bit SW_EN = 1'b1;
`else
   localparam bit SW_EN = 1'b0;
`endif

   // reference state: edges seen since reset release, and restart edges
   int n     = 0;
   int swb_a = -1;
   int swb_b = -1;

   logic [5:0] ea;
   logic [5:0] eb;
   logic [5:0] pre_a;
   logic [5:0] pre_b;

   reset_sequencer dut_a (
      .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
      .rst_out_n(a_out), .rst_done(a_done), .seq_state(a_state)
   );

   reset_sequencer #(
      .SYNC_STAGES(2), .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)
   ) dut_b (
      .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
      .rst_out_n(b_out), .rst_done(b_done), .seq_state(b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {rst_out_n[2:0], rst_done, seq_state} after n counted edges.
   function automatic logic [5:0] ref_model(input int cnt, input int swb, input int ss,
                                            input int h, input int g, input int ns,
                                            input logic rst_now);
      logic [2:0] bits;
      logic       dn;
      logic [1:0] st;
      int         rb;
      if (!rst_now) return 6'd0;
      rb   = (swb >= 0) ? swb + h : ss + h;
      bits = '0;
      for (int k = 0; k < ns; k++) if (cnt >= rb + k * g) bits[k] = 1'b1;
      dn = (cnt >= rb + (ns - 1) * g);
      st = dn ? 2'd2 : ((cnt >= rb) ? 2'd1 : 2'd0);
      return {bits, dn, st};
   endfunction

   always @(negedge rst) begin
      n     = 0;
      swb_a = -1;
      swb_b = -1;
   end

   always @(posedge clk) begin
      if (rst) begin
         pre_a = ref_model(n, swb_a, 2, 16, 4, 3, 1'b1);
         pre_b = ref_model(n, swb_b, 2, 1, 1, 1, 1'b1);
         if (SW_EN && sw_rst_req && pre_a[1:0] == 2'd2) swb_a = n + 1;
         if (SW_EN && sw_rst_req && pre_b[1:0] == 2'd2) swb_b = n + 1;
         n = n + 1;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      sw_rst_req = 1'b0;
      #1 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL reset_a t=%0t got=%b want=%b", $time, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL reset_b t=%0t got=%b want=%b", $time, {2'b00, b_out, b_done, b_state}, eb);
         end
      end
      #3 rst = 1'b1;
   endtask

   task automatic test_power_on();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL power_on_a edge=%0d got=%b want=%b", n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL power_on_b edge=%0d got=%b want=%b", n, {2'b00, b_out, b_done, b_state}, eb);
         end
      end
   endtask

   task automatic test_mid_rel_reset();
      int lo_cycles;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 40 && n != 19; i++) @(negedge clk);
      total++;
      if (n != 19) begin
         bad++;
         $display("FAIL mid_rel_wait edge=%0d want=19", n);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
      total++;
      if ({a_out, a_done, a_state} !== ea) begin
         bad++;
         $display("FAIL mid_rel_async got=%b want=%b", {a_out, a_done, a_state}, ea);
      end
      lo_cycles = $urandom_range(1, 3);
      repeat (lo_cycles) @(negedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL mid_rel_a edge=%0d got=%b want=%b", n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL mid_rel_b edge=%0d got=%b want=%b", n, {2'b00, b_out, b_done, b_state}, eb);
         end
      end
   endtask

   task automatic test_done_glitch();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
      eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
      total++;
      if ({a_out, a_done, a_state, b_out, b_done, b_state} !== {ea, eb[3:0]}) begin
         bad++;
         $display("FAIL glitch_async got=%b want=%b",
                  {a_out, a_done, a_state, b_out, b_done, b_state}, {ea, eb[3:0]});
      end
      #1 rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL glitch_a edge=%0d got=%b want=%b", n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL glitch_b edge=%0d got=%b want=%b", n, {2'b00, b_out, b_done, b_state}, eb);
         end
      end
   endtask

   // sw_rst_req sampled at edge 40 while in DONE
   task automatic test_sw_reset();
      for (int i = 0; i < 100 && n < 72; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL sw_done_a edge=%0d got=%b want=%b", n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL sw_done_b edge=%0d got=%b want=%b", n, {2'b00, b_out, b_done, b_state}, eb);
         end
         sw_rst_req = (n == 39);
      end
      sw_rst_req = 1'b0;
   endtask

   // sw_rst_req sampled at edge 20 while the default instance is in REL
   task automatic test_sw_in_rel();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL sw_rel_a edge=%0d got=%b want=%b", n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL sw_rel_b edge=%0d got=%b want=%b", n, {2'b00, b_out, b_done, b_state}, eb);
         end
         sw_rst_req = (n == 19);
      end
      sw_rst_req = 1'b0;
   endtask

   task automatic test_random();
      int low_left = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         ea = ref_model(n, swb_a, 2, 16, 4, 3, rst);
         eb = ref_model(n, swb_b, 2, 1, 1, 1, rst);
         total++;
         if ({a_out, a_done, a_state} !== ea) begin
            bad++;
            $display("FAIL random_a cyc=%0d edge=%0d got=%b want=%b", i, n, {a_out, a_done, a_state}, ea);
         end
         total++;
         if ({2'b00, b_out, b_done, b_state} !== eb) begin
            bad++;
            $display("FAIL random_b cyc=%0d edge=%0d got=%b want=%b", i, n, {2'b00, b_out, b_done, b_state}, eb);
         end
         sw_rst_req = ($urandom_range(0, 11) == 0);
         if (low_left > 0) begin
            low_left--;
            if (low_left == 0) #2 rst = 1'b1;
         end else if ($urandom_range(0, 59) == 0) begin
            #1 rst = 1'b0;
            low_left = $urandom_range(0, 3);
            #1;
            total++;
            if ({a_out, a_done, a_state, b_out, b_done, b_state} !== 10'd0) begin
               bad++;
               $display("FAIL random_async cyc=%0d got=%b want=0", i,
                        {a_out, a_done, a_state, b_out, b_done, b_state});
            end
            if (low_left == 0) #1 rst = 1'b1;
         end
      end
      sw_rst_req = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_mid_rel_reset();
      test_done_glitch();
      test_sw_reset();
      test_sw_in_rel();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
